// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if
//   Groups every signal between the multi-cycle sequencer and the rest of the
//   core (instruction memory, ALU decoder, PC, register file, data memory).
//   Parameters:
//     IW     instruction width ([8:7] class, [6:3] funct, [2:0] operand)
//     CNT_W  width of the retired-instruction counter
//   Signals (seen from the sequencer, modport master):
//     in : instr, alu_zero, mem_ready, start
//     out: state, ir_load, alu_op, funct, pc_inc, pc_load, pc_clear,
//          reg_write, wb_sel, mem_rd, mem_wr, done, retired
//   The slave modport is the datapath view of the same signals.
interface mc_sequencer_if #(
    parameter int IW    = 9,
    parameter int CNT_W = 16
);
    logic [IW-1:0]    instr;
    logic             alu_zero;
    logic             mem_ready;
    logic             start;

    logic [2:0]       state;
    logic             ir_load;
    logic [1:0]       alu_op;
    logic [3:0]       funct;
    logic             pc_inc;
    logic             pc_load;
    logic             pc_clear;
    logic             reg_write;
    logic             wb_sel;
    logic             mem_rd;
    logic             mem_wr;
    logic             done;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr, alu_zero, mem_ready, start,
        output state, ir_load, alu_op, funct, pc_inc, pc_load, pc_clear,
               reg_write, wb_sel, mem_rd, mem_wr, done, retired
    );

    modport slave (
        output instr, alu_zero, mem_ready, start,
        input  state, ir_load, alu_op, funct, pc_inc, pc_load, pc_clear,
               reg_write, wb_sel, mem_rd, mem_wr, done, retired
    );
endinterface

// File: rtl/mc_sequencer.sv
// mc_sequencer
//   Multi-cycle control FSM: walks each instruction through fetch, decode,
//   execute, memory and writeback, and counts retired instructions.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    mc_sequencer_if.master (instruction in, ALU/mem status in,
//            start in; state, strobes, alu_op, funct, done, retired out)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FETCH  | latch instr into IR (ir_load)
//   DECODE | detect halt, otherwise go execute
//   EXEC   | ALU op from IR class; branches/NOPs finish here
//   MEM    | hold mem_rd/mem_wr until mem_ready; store finishes here
//   WB     | register write, PC increment
//   HALT   | done=1, wait for start (clears PC)
module mc_sequencer #(
    parameter int IW    = 9,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    mc_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    // Only class and funct are kept; the operand field is consumed by the
    // datapath straight from instruction memory.
    logic [5:0]       ir_q;
    logic [CNT_W-1:0] retired_q;

    logic [1:0] ir_class;
    logic [3:0] ir_funct;
    logic       is_halt;
    logic       is_load;
    logic       is_store;

    logic       ir_load;
    logic [1:0] alu_op;
    logic       pc_inc;
    logic       pc_load;
    logic       pc_clear;
    logic       reg_write;
    logic       wb_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       done;

    logic       unused_operand;

    assign unused_operand = ^bus.instr[IW-7:0];

    assign ir_class = ir_q[5:4];
    assign ir_funct = ir_q[3:0];
    assign is_halt  = (ir_class == 2'b11) && (ir_funct == 4'b1111);
    assign is_load  = (ir_class == 2'b11) && (ir_funct == 4'b0000);
    assign is_store = (ir_class == 2'b11) && (ir_funct == 4'b0001);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= bus.instr[IW-1 -: 6];
            end
            // Saturating: the count sticks at all-ones instead of wrapping.
            if ((pc_inc || pc_load) && (retired_q != {CNT_W{1'b1}})) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_load   = 1'b0;
        alu_op    = 2'b11;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_clear  = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_load = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alu_op = ir_class;
                case (ir_class)
                    2'b00, 2'b01: begin
                        state_d = S_WB;
                    end
                    2'b10: begin
                        // funct[3] set means unconditional jump
                        if (ir_funct[3] || bus.alu_zero) begin
                            pc_load = 1'b1;
                        end else begin
                            pc_inc = 1'b1;
                        end
                        state_d = S_FETCH;
                    end
                    default: begin
                        if (is_load || is_store) begin
                            state_d = S_MEM;
                        end else begin
                            pc_inc  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEM: begin
                mem_rd = is_load;
                mem_wr = is_store;
                if (bus.mem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_inc  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_inc    = 1'b1;
                wb_sel    = is_load;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                done = 1'b1;
                if (bus.start) begin
                    pc_clear = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign bus.state     = state_q;
    assign bus.ir_load   = ir_load;
    assign bus.alu_op    = alu_op;
    assign bus.funct     = ir_funct;
    assign bus.pc_inc    = pc_inc;
    assign bus.pc_load   = pc_load;
    assign bus.pc_clear  = pc_clear;
    assign bus.reg_write = reg_write;
    assign bus.wb_sel    = wb_sel;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.done      = done;
    assign bus.retired   = retired_q;

endmodule
